// File: rtl/d_latch_unit_if.sv
// d_latch_unit_if: data/enable inputs and latch status outputs of d_latch_unit.
// PAR exists only when D_LATCH_UNIT_PARITY_EN is defined.
interface d_latch_unit_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] D;
    logic             EN;
    logic [WIDTH-1:0] Q;
    logic [WIDTH-1:0] Q_HOLD;
    logic             OPEN;
    logic             CHG;
    logic [15:0]      CLOSE_CNT;
`ifdef D_LATCH_UNIT_PARITY_EN
    logic             PAR;
`endif

`ifdef D_LATCH_UNIT_PARITY_EN
    modport master (
        output D, EN,
        input  Q, Q_HOLD, OPEN, CHG, CLOSE_CNT, PAR
    );
    modport slave (
        input  D, EN,
        output Q, Q_HOLD, OPEN, CHG, CLOSE_CNT, PAR
    );
`else
    modport master (
        output D, EN,
        input  Q, Q_HOLD, OPEN, CHG, CLOSE_CNT
    );
    modport slave (
        input  D, EN,
        output Q, Q_HOLD, OPEN, CHG, CLOSE_CNT
    );
`endif
endinterface

// File: rtl/d_latch_unit.sv
// d_latch_unit: transparent D latch emulated with a clocked hold register.
// Define D_LATCH_UNIT_PARITY_EN to add PAR, a registered even parity of the hold value.
module d_latch_unit #(
    parameter int WIDTH = 1
) (
    input  logic          CLK,
    input  logic          RST,
    d_latch_unit_if.slave io_lat
);
    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("d_latch_unit: WIDTH must be 1..64");
    end

    logic [WIDTH-1:0] r_h;
    logic             r_open;
    logic             r_chg;
    logic [15:0]      r_close_cnt;

    logic w_close;
    logic w_sat;
    logic w_diff;

    assign w_close = r_open & ~io_lat.EN;
    assign w_sat   = &r_close_cnt;
    assign w_diff  = (io_lat.D != r_h);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_h         <= '0;
            r_open      <= 1'b0;
            r_chg       <= 1'b0;
            r_close_cnt <= '0;
        end else begin
            if (io_lat.EN) begin
                r_h <= io_lat.D;
            end
            r_open <= io_lat.EN;
            r_chg  <= io_lat.EN & w_diff;
            // Counter sticks at all-ones rather than wrapping
            if (w_close && !w_sat) begin
                r_close_cnt <= r_close_cnt + 16'd1;
            end
        end
    end

    // Pure mux: no register between D and Q while transparent
    assign io_lat.Q         = RST ? '0 : (io_lat.EN ? io_lat.D : r_h);
    assign io_lat.Q_HOLD    = r_h;
    assign io_lat.OPEN      = r_open;
    assign io_lat.CHG       = r_chg;
    assign io_lat.CLOSE_CNT = r_close_cnt;

`ifdef D_LATCH_UNIT_PARITY_EN
    logic r_par;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_par <= 1'b0;
        end else if (io_lat.EN) begin
            r_par <= ^io_lat.D;
        end
    end

    assign io_lat.PAR = r_par;
`endif
endmodule

// File: tb/tb_d_latch_unit.sv
// tb_d_latch_unit: directed and randomized checks of d_latch_unit (WIDTH=8)
// against a cycle-level model of the latch rules.
module tb_d_latch_unit;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [W-1:0] cur_d;
    logic         cur_en;
    logic [W-1:0] m_h;
    logic         m_open;
    logic         m_chg;
    logic [15:0]  m_cnt;

    d_latch_unit_if #(.WIDTH(W)) bus ();

    d_latch_unit #(.WIDTH(W)) dut (
        .CLK    (clk),
        .RST    (rst),
        .io_lat (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_h    = '0;
        m_open = 1'b0;
        m_chg  = 1'b0;
        m_cnt  = '0;
    endtask

    task automatic drive(input logic [W-1:0] d, input logic en);
        @(negedge clk);
        cur_d  = d;
        cur_en = en;
        bus.D  = d;
        bus.EN = en;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        m_chg = cur_en && (cur_d != m_h);
        if (cur_en) m_h = cur_d;
        if (m_open && !cur_en && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_open = cur_en;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cur_d = '0; cur_en = 1'b0;
        bus.D = '0; bus.EN = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.D = 8'h01; bus.EN = 1'b1;
        cur_d = 8'h01; cur_en = 1'b1;
        #1;
        checks++;
        if (bus.Q !== 8'h00) begin
            errors++; $display("FAIL reset_q: got %h expected 00", bus.Q);
        end
        @(posedge clk); #1;
        checks++;
        if (bus.Q !== 8'h00 || bus.Q_HOLD !== 8'h00) begin
            errors++; $display("FAIL reset_hold: q %h qh %h expected 00 00", bus.Q, bus.Q_HOLD);
        end
        checks++;
        if (bus.CLOSE_CNT !== 16'h0 || bus.OPEN !== 1'b0 || bus.CHG !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: cnt %h open %b chg %b expected 0000 0 0",
                     bus.CLOSE_CNT, bus.OPEN, bus.CHG);
        end
`ifdef D_LATCH_UNIT_PARITY_EN
        checks++;
        if (bus.PAR !== 1'b0) begin
            errors++; $display("FAIL reset_par: got %b expected 0", bus.PAR);
        end
`endif
        @(negedge clk);
        bus.EN = 1'b0; cur_en = 1'b0;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus.Q !== 8'h00) begin
            errors++; $display("FAIL release_q: got %h expected 00", bus.Q);
        end
        tick();
        checks++;
        if (bus.Q !== 8'h00 || bus.OPEN !== 1'b0 || bus.CLOSE_CNT !== 16'h0) begin
            errors++;
            $display("FAIL release_edge: q %h open %b cnt %h expected 00 0 0000",
                     bus.Q, bus.OPEN, bus.CLOSE_CNT);
        end
    endtask

    task automatic test_open_close();
        drive(8'h01, 1'b1);
        checks++;
        if (bus.Q !== 8'h01) begin
            errors++; $display("FAIL open_q: got %h expected 01", bus.Q);
        end
        tick();
        checks++;
        if (bus.Q_HOLD !== 8'h01 || bus.CHG !== 1'b1 || bus.OPEN !== 1'b1) begin
            errors++;
            $display("FAIL open_edge: qh %h chg %b open %b expected 01 1 1",
                     bus.Q_HOLD, bus.CHG, bus.OPEN);
        end
        drive(8'h00, 1'b0);
        checks++;
        if (bus.Q !== 8'h01) begin
            errors++; $display("FAIL close_q: got %h expected 01", bus.Q);
        end
        tick();
        checks++;
        if (bus.Q !== 8'h01 || bus.CHG !== 1'b0 || bus.CLOSE_CNT !== 16'd1) begin
            errors++;
            $display("FAIL close_edge: q %h chg %b cnt %h expected 01 0 0001",
                     bus.Q, bus.CHG, bus.CLOSE_CNT);
        end
    endtask

    task automatic test_reenable();
        drive(8'h01, 1'b1);
        checks++;
        if (bus.Q !== 8'h01) begin
            errors++; $display("FAIL reopen_q: got %h expected 01", bus.Q);
        end
        tick();
        checks++;
        if (bus.CHG !== 1'b0) begin
            errors++; $display("FAIL reopen_nochg: got %b expected 0", bus.CHG);
        end
        drive(8'h00, 1'b1);
        checks++;
        if (bus.Q !== 8'h00) begin
            errors++; $display("FAIL transp_q: got %h expected 00", bus.Q);
        end
        tick();
        checks++;
        if (bus.CHG !== 1'b1 || bus.Q_HOLD !== 8'h00) begin
            errors++; $display("FAIL transp_chg: chg %b qh %h expected 1 00", bus.CHG, bus.Q_HOLD);
        end
        drive(8'h00, 1'b1);
        tick();
        checks++;
        if (bus.CHG !== 1'b0) begin
            errors++; $display("FAIL chg_single: got %b expected 0", bus.CHG);
        end
        drive(8'h00, 1'b0);
        tick();
        checks++;
        if (bus.CLOSE_CNT !== 16'd2) begin
            errors++; $display("FAIL cnt_two: got %h expected 0002", bus.CLOSE_CNT);
        end
    endtask

    task automatic test_wide_hold();
        drive(8'hA5, 1'b1);
        tick();
        drive(8'h3C, 1'b0);
        checks++;
        if (bus.Q !== 8'hA5 || bus.Q_HOLD !== 8'hA5) begin
            errors++; $display("FAIL wide_pre: q %h qh %h expected a5 a5", bus.Q, bus.Q_HOLD);
        end
        tick();
        checks++;
        if (bus.Q !== 8'hA5 || bus.Q_HOLD !== 8'hA5 || bus.CHG !== 1'b0) begin
            errors++;
            $display("FAIL wide_post: q %h qh %h chg %b expected a5 a5 0", bus.Q, bus.Q_HOLD, bus.CHG);
        end
`ifdef D_LATCH_UNIT_PARITY_EN
        checks++;
        if (bus.PAR !== 1'b0) begin
            errors++; $display("FAIL wide_par: got %b expected 0", bus.PAR);
        end
        drive(8'h07, 1'b1);
        tick();
        checks++;
        if (bus.PAR !== 1'b1) begin
            errors++; $display("FAIL odd_par: got %b expected 1", bus.PAR);
        end
        drive(8'h00, 1'b0);
        tick();
`endif
    endtask

    task automatic test_async_reset();
        drive(8'h00, 1'b1);
        tick();
        drive(8'h01, 1'b1);
        tick();
        drive(8'h01, 1'b0);
        checks++;
        if (bus.Q !== 8'h01 || bus.CHG !== 1'b1 || bus.OPEN !== 1'b1) begin
            errors++;
            $display("FAIL pre_async: q %h chg %b open %b expected 01 1 1", bus.Q, bus.CHG, bus.OPEN);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.Q !== 8'h00 || bus.Q_HOLD !== 8'h00 || bus.OPEN !== 1'b0 ||
            bus.CHG !== 1'b0 || bus.CLOSE_CNT !== 16'h0) begin
            errors++;
            $display("FAIL async_clear: q %h qh %h open %b chg %b cnt %h expected all zero",
                     bus.Q, bus.Q_HOLD, bus.OPEN, bus.CHG, bus.CLOSE_CNT);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        drive(8'h55, 1'b0);
        tick();
        checks++;
        if (bus.Q !== 8'h00 || bus.Q_HOLD !== 8'h00 || bus.CLOSE_CNT !== 16'h0) begin
            errors++;
            $display("FAIL post_async: q %h qh %h cnt %h expected 00 00 0000",
                     bus.Q, bus.Q_HOLD, bus.CLOSE_CNT);
        end
    endtask

    task automatic test_count();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(W'($urandom()), 1'b1);
            tick();
            drive(W'($urandom()), 1'b0);
            tick();
        end
        checks++;
        if (bus.CLOSE_CNT !== 16'd300 || m_cnt !== 16'd300) begin
            errors++; $display("FAIL count_300: got %h expected 012c", bus.CLOSE_CNT);
        end
    endtask

    task automatic test_saturation();
        drive(8'h00, 1'b0);
        tick();
        @(negedge clk);
        force dut.r_close_cnt = 16'hFFF0;
        #1;
        release dut.r_close_cnt;
        m_cnt = 16'hFFF0;
        checks++;
        if (bus.CLOSE_CNT !== 16'hFFF0) begin
            errors++; $display("FAIL preload: got %h expected fff0", bus.CLOSE_CNT);
        end
        for (int i = 0; i < 24; i++) begin
            drive(W'($urandom()), 1'b1);
            tick();
            drive(W'($urandom()), 1'b0);
            tick();
            checks++;
            if (bus.CLOSE_CNT !== m_cnt) begin
                errors++; $display("FAIL sat_step %0d: got %h expected %h", i, bus.CLOSE_CNT, m_cnt);
            end
        end
        checks++;
        if (bus.CLOSE_CNT !== 16'hFFFF) begin
            errors++; $display("FAIL sat_final: got %h expected ffff", bus.CLOSE_CNT);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] d;
        logic         en;
        logic [W-1:0] exp_q;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            en = 1'($urandom_range(0, 1));
            d  = ($urandom_range(0, 3) == 0) ? m_h : W'($urandom());
            drive(d, en);
            exp_q = en ? d : m_h;
            checks++;
            if (bus.Q !== exp_q) begin
                errors++; $display("FAIL rnd_q %0d: got %h expected %h", i, bus.Q, exp_q);
            end
            tick();
            checks++;
            if (bus.Q_HOLD !== m_h || bus.OPEN !== m_open || bus.CHG !== m_chg ||
                bus.CLOSE_CNT !== m_cnt) begin
                errors++;
                $display("FAIL rnd_state %0d: qh %h open %b chg %b cnt %h expected %h %b %b %h",
                         i, bus.Q_HOLD, bus.OPEN, bus.CHG, bus.CLOSE_CNT,
                         m_h, m_open, m_chg, m_cnt);
            end
`ifdef D_LATCH_UNIT_PARITY_EN
            checks++;
            if (bus.PAR !== ^m_h) begin
                errors++; $display("FAIL rnd_par %0d: got %b expected %b", i, bus.PAR, ^m_h);
            end
`endif
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        cur_d  = '0;
        cur_en = 1'b0;
        bus.D  = '0;
        bus.EN = 1'b0;
        model_reset();
        test_reset();
        test_open_close();
        test_reenable();
        test_wide_hold();
        test_async_reset();
        test_count();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
